// File: rtl/ysyx_22050612_pkg.sv
// Shared definitions for the NPC multi-cycle control path:
// sequencer state encoding, halt causes and the reset PC.
package ysyx_22050612_pkg;

  typedef enum logic [2:0] {
    CTRL_IDLE  = 3'd0,
    CTRL_FETCH = 3'd1,
    CTRL_EXEC  = 3'd2,
    CTRL_MEM   = 3'd3,
    CTRL_WB    = 3'd4,
    CTRL_HALT  = 3'd5
  } ctrl_state_e;

  localparam logic HALT_EBREAK   = 1'b0;
  localparam logic HALT_MISALIGN = 1'b1;

  localparam logic [63:0] CTRL_RESET_PC = 64'h8000_0000;

  function automatic logic pc_misaligned(
    input logic [1:0] lo
  );
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22050612_perf_cnt.sv
// Cycle and retired-instruction counters for the sequencer.
// Only built when CTRL_PERF_EN is defined.
`ifdef CTRL_PERF_EN
module ysyx_22050612_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_i,
  input  logic        retire_i,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instret_cnt_o
);

  logic [63:0] cycle_q, cycle_d;
  logic [63:0] instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (run_i) begin
      cycle_d = cycle_q + 64'd1;
    end
    if (retire_i) begin
      instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt_o   = cycle_q;
  assign instret_cnt_o = instret_q;

endmodule
`endif

// File: rtl/ysyx_22050612_ctrl.sv
// Multi-cycle sequencer: FETCH -> EXEC -> (MEM) -> WB, owns PC.
// CTRL_PERF_EN adds cycle_cnt / instret_cnt outputs.
module ysyx_22050612_ctrl
  import ysyx_22050612_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(CTRL_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req,
  output logic [XLEN-1:0] ifu_addr,
  input  logic            ifu_rvalid,
  input  logic [31:0]     ifu_rdata,
  output logic [31:0]     inst,
  input  logic            is_load,
  input  logic            is_store,
  input  logic            is_ebreak,
  input  logic [XLEN-1:0] dnpc,
  input  logic            exu_wen,
  input  logic [4:0]      rd,
  output logic            lsu_req,
  output logic            lsu_we,
  input  logic            lsu_done,
  output logic            gpr_wen,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halt,
  output logic            halt_code
`ifdef CTRL_PERF_EN
  ,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
`endif
);

  ctrl_state_e     state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic [31:0]     inst_q, inst_d;
  logic            load_q, load_d;
  logic            store_q, store_d;
  logic            halt_q, halt_d;
  logic            hcode_q, hcode_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    inst_d  = inst_q;
    load_d  = load_q;
    store_d = store_q;
    halt_d  = halt_q;
    hcode_d = hcode_q;
    ifu_req = 1'b0;
    lsu_req = 1'b0;
    lsu_we  = 1'b0;
    gpr_wen = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      CTRL_IDLE: begin
        state_d = CTRL_FETCH;
      end
      CTRL_FETCH: begin
        ifu_req = 1'b1;
        if (ifu_rvalid) begin
          inst_d  = ifu_rdata;
          state_d = CTRL_EXEC;
        end
      end
      CTRL_EXEC: begin
        // ebreak wins over a bad target: it never jumps
        if (is_ebreak) begin
          halt_d  = 1'b1;
          hcode_d = HALT_EBREAK;
          state_d = CTRL_HALT;
        end else if (pc_misaligned(dnpc[1:0])) begin
          halt_d  = 1'b1;
          hcode_d = HALT_MISALIGN;
          state_d = CTRL_HALT;
        end else begin
          npc_d   = dnpc;
          load_d  = is_load;
          store_d = is_store;
          if (is_load || is_store) begin
            state_d = CTRL_MEM;
          end else begin
            state_d = CTRL_WB;
          end
        end
      end
      CTRL_MEM: begin
        lsu_req = 1'b1;
        lsu_we  = store_q;
        if (lsu_done) begin
          state_d = CTRL_WB;
        end
      end
      CTRL_WB: begin
        gpr_wen = (exu_wen | load_q) & ~store_q & (rd != 5'd0);
        retire  = 1'b1;
        pc_d    = npc_q;
        state_d = CTRL_FETCH;
      end
      CTRL_HALT: begin
        state_d = CTRL_HALT;
      end
      default: begin
        state_d = CTRL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CTRL_IDLE;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC;
      inst_q  <= '0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      halt_q  <= 1'b0;
      hcode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      inst_q  <= inst_d;
      load_q  <= load_d;
      store_q <= store_d;
      halt_q  <= halt_d;
      hcode_q <= hcode_d;
    end
  end

  assign ifu_addr  = pc_q;
  assign pc        = pc_q;
  assign inst      = inst_q;
  assign halt      = halt_q;
  assign halt_code = hcode_q;

`ifdef CTRL_PERF_EN
  ysyx_22050612_perf_cnt u_perf (
    .clk           (clk),
    .rst           (rst),
    .run_i         (~halt_q),
    .retire_i      (retire),
    .cycle_cnt_o   (cycle_cnt),
    .instret_cnt_o (instret_cnt)
  );
`endif

endmodule

// File: tb/tb_ysyx_22050612_ctrl.sv
// Self-checking bench for ysyx_22050612_ctrl.
// Retire events are scored against a queue filled at fetch time.
module tb_ysyx_22050612_ctrl;

  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req;
  logic [63:0] ifu_addr;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic [31:0] inst;
  logic        is_load, is_store, is_ebreak;
  logic [63:0] dnpc;
  logic        exu_wen;
  logic [4:0]  rd;
  logic        lsu_req, lsu_we, lsu_done;
  logic        gpr_wen;
  logic [63:0] pc;
  logic        retire, halt, halt_code;
`ifdef CTRL_PERF_EN
  logic [63:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  ysyx_22050612_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ifu_req    (ifu_req),
    .ifu_addr   (ifu_addr),
    .ifu_rvalid (ifu_rvalid),
    .ifu_rdata  (ifu_rdata),
    .inst       (inst),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_ebreak  (is_ebreak),
    .dnpc       (dnpc),
    .exu_wen    (exu_wen),
    .rd         (rd),
    .lsu_req    (lsu_req),
    .lsu_we     (lsu_we),
    .lsu_done   (lsu_done),
    .gpr_wen    (gpr_wen),
    .pc         (pc),
    .retire     (retire),
    .halt       (halt),
    .halt_code  (halt_code)
`ifdef CTRL_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  typedef struct packed {
    logic [63:0] pc;
    logic        wen;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] exp_pc;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    ifu_rvalid = 1'b0;
    ifu_rdata  = '0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_ebreak  = 1'b0;
    dnpc       = '0;
    exu_wen    = 1'b0;
    rd         = '0;
    lsu_done   = 1'b0;
  endtask

  // leaves the DUT in its first FETCH cycle
  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    step();
    step();
    chk("rst_ifu_req", ifu_req, 0);
    chk("rst_lsu_req", lsu_req, 0);
    chk("rst_lsu_we", lsu_we, 0);
    chk("rst_gpr_wen", gpr_wen, 0);
    chk("rst_retire", retire, 0);
    chk("rst_halt", halt, 0);
    chk("rst_hcode", halt_code, 0);
    chk("rst_pc", pc, RPC);
    chk("rst_inst", inst, 0);
    rst = 1'b0;
    exp_pc = RPC;
    chk("idle_req", ifu_req, 0);
    step();
  endtask

  task automatic run_inst(input logic [31:0] ins, input int fdly,
                          input bit ld, input bit st, input int mdly,
                          input logic [63:0] np, input bit ew,
                          input logic [4:0] rdv, input bit want_wen);
    ifu_rdata  = ins;
    ifu_rvalid = 1'b0;
    repeat (fdly) begin
      chk("stall_req", ifu_req, 1);
      chk("stall_addr", ifu_addr, exp_pc);
      chk("stall_retire", retire, 0);
      step();
    end
    ifu_rvalid = 1'b1;
    chk("fetch_req", ifu_req, 1);
    chk("fetch_addr", ifu_addr, exp_pc);
    sbq.push_back('{pc: exp_pc, wen: want_wen});
    is_load   = ld;
    is_store  = st;
    is_ebreak = 1'b0;
    dnpc      = np;
    exu_wen   = ew;
    rd        = rdv;
    step();
    ifu_rvalid = 1'b0;
    ifu_rdata  = 32'hdead_beef;
    chk("exec_inst", inst, ins);
    chk("exec_req", ifu_req, 0);
    chk("exec_retire", retire, 0);
    step();
    if (ld || st) begin
      for (int m = 0; m < mdly; m++) begin
        lsu_done = (m == mdly - 1);
        chk("mem_req", lsu_req, 1);
        chk("mem_we", lsu_we, st);
        chk("mem_wen", gpr_wen, 0);
        chk("mem_retire", retire, 0);
        step();
      end
      lsu_done = 1'b0;
    end
    chk("wb_retire", retire, 1);
    chk("wb_wen", gpr_wen, want_wen);
    chk("wb_inst", inst, ins);
    chk("wb_lsu_req", lsu_req, 0);
    step();
    exp_pc = np;
    chk("pc_upd", pc, exp_pc);
    chk("post_retire", retire, 0);
  endtask

  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (!rst && retire) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_retire", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("sb_pc", pc, e.pc);
        chk("sb_wen", gpr_wen, e.wen);
      end
    end
  end

  initial begin
    rst = 1'b1;
    clr_in();
    do_reset();

    // addi x5,x0,5 straight out of reset
    run_inst(32'h0050_0293, 0, 0, 0, 0, RPC + 64'h4, 1, 5'd5, 1);
    // five-cycle fetch stall
    run_inst(32'h0010_0313, 5, 0, 0, 0, RPC + 64'h8, 1, 5'd6, 1);
    // load to x0, three MEM cycles
    run_inst(32'h0000_3003, 0, 1, 0, 3, RPC + 64'hc, 0, 5'd0, 0);
    // load to x7 writes through load_q alone
    run_inst(32'h0000_3383, 0, 1, 0, 1, RPC + 64'h20, 0, 5'd7, 1);
    // store never writes even with exu_wen
    run_inst(32'h0050_3023, 0, 0, 1, 2, 64'h8000_0010, 1, 5'd5, 0);
    // ALU op without write request
    run_inst(32'h0000_0013, 0, 0, 0, 0, RPC + 64'h14, 0, 5'd9, 0);
    // PC wrap-around is legal
    run_inst(32'h0000_006f, 0, 0, 0, 0, 64'hffff_ffff_ffff_fffc, 1, 5'd1, 1);
    run_inst(32'h0000_006f, 1, 0, 0, 0, 64'h0, 1, 5'd1, 1);

    // reset in the middle of MEM, lsu_done arriving late
    do_reset();
    ifu_rdata  = 32'h0000_3183;
    ifu_rvalid = 1'b1;
    is_load    = 1'b1;
    dnpc       = RPC + 64'h4;
    exu_wen    = 1'b1;
    rd         = 5'd3;
    step();
    ifu_rvalid = 1'b0;
    step();
    chk("rmem_req", lsu_req, 1);
    rst = 1'b1;
    step();
    rst      = 1'b0;
    lsu_done = 1'b1;
    chk("rmem_req_drop", lsu_req, 0);
    chk("rmem_wen", gpr_wen, 0);
    chk("rmem_retire", retire, 0);
    chk("rmem_pc", pc, RPC);
    chk("rmem_inst", inst, 0);
    step();
    lsu_done = 1'b0;
    chk("rmem_fetch", ifu_req, 1);
    chk("rmem_lsu_req", lsu_req, 0);
    chk("rmem_retire2", retire, 0);
    chk("rmem_pc2", pc, RPC);

    // misaligned dnpc halts; responses afterwards are ignored
    do_reset();
    ifu_rdata  = 32'h0060_006f;
    ifu_rvalid = 1'b1;
    dnpc       = RPC + 64'h6;
    exu_wen    = 1'b1;
    rd         = 5'd1;
    step();
    ifu_rvalid = 1'b0;
    chk("mis_exec_halt", halt, 0);
    step();
    chk("mis_halt", halt, 1);
    chk("mis_hcode", halt_code, 1);
    ifu_rvalid = 1'b1;
    lsu_done   = 1'b1;
    repeat (10) begin
      chk("mis_ifu_req", ifu_req, 0);
      chk("mis_lsu_req", lsu_req, 0);
      chk("mis_wen", gpr_wen, 0);
      chk("mis_retire", retire, 0);
      chk("mis_pc", pc, RPC);
      chk("mis_halt_hold", halt, 1);
      step();
    end

    // ebreak wins over a misaligned dnpc
    do_reset();
    ifu_rdata  = 32'h0010_0073;
    ifu_rvalid = 1'b1;
    is_ebreak  = 1'b1;
    dnpc       = RPC + 64'h2;
    step();
    ifu_rvalid = 1'b0;
    chk("ebr_exec_halt", halt, 0);
    step();
    chk("ebr_halt", halt, 1);
    chk("ebr_hcode", halt_code, 0);
    repeat (3) begin
      chk("ebr_ifu_req", ifu_req, 0);
      chk("ebr_retire", retire, 0);
      chk("ebr_pc", pc, RPC);
      step();
    end

    chk("sb_left", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
